dev_keypad: RTL and testbench



---
 rtl/dev_keypad.sv | 204 ++++++++++++++++++++
 tb/tb_dev_keypad.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_keypad.sv
// dev_keypad: 4x4 active-low matrix keypad scanner with whole-scan debounce
// and a valid/ack holding stage for key codes.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   row_pins   row drive, active-low, one row low at a time (registered)
//   col_pins   column sense, active-low, asynchronous
//   key_valid  a key code is pending
//   key_code   pending code = row*4 + col
//   key_ack    consumer pops the pending code
//   key_down   debounced "some key held"
//   overflow   sticky, a press event was dropped
//
// Build option: define KEYPAD_FIFO_EN to replace the single holding register
// with a FIFO_DEPTH-entry queue (FIFO_DEPTH must be a power of two >= 2).
module dev_keypad #(
  parameter int unsigned SCAN_DIV       = 3000,
  parameter int unsigned DEBOUNCE_SCANS = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_pins,
  input  logic [3:0] col_pins,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overflow
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2) begin : g_param_check
    $error("dev_keypad: illegal parameter value");
  end

  logic [3:0]        col_meta, col_sync;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        row;
  logic              acc_pressed;
  logic [3:0]        acc_code;
  logic              prev_pressed;
  logic [3:0]        prev_code;
  logic [CNT_W-1:0]  stable_cnt;
  logic [3:0]        deb_code;

  logic              slot_end, scan_end, same, reach, press_event;
  logic [3:0]        col_low;
  logic              row_hit;
  logic [1:0]        low_col;
  logic              cand_pressed;
  logic [3:0]        cand_code;
  logic [CNT_W-1:0]  next_cnt;

  // Merge this row's sample into the running scan candidate and evaluate debounce.
  always_comb begin
    slot_end     = (slot == SLOT_W'(SCAN_DIV - 1));
    scan_end     = slot_end && (row == 2'd3);
    col_low      = ~col_sync;
    row_hit      = |col_low;
    low_col      = 2'd0;
    cand_pressed = acc_pressed;
    cand_code    = acc_code;
    for (int c = 3; c >= 0; c--) begin
      if (col_low[c]) low_col = 2'(c);
    end
    // Row 0 starts a fresh scan; later rows only fill in if nothing lower was seen.
    if (row == 2'd0 || !acc_pressed) begin
      cand_pressed = row_hit;
      cand_code    = row_hit ? {row, low_col} : 4'd0;
    end
    same = ({cand_pressed, cand_code} == {prev_pressed, prev_code});
    if (!same) begin
      next_cnt = CNT_W'(1);
    end else if (stable_cnt == CNT_W'(DEBOUNCE_SCANS)) begin
      next_cnt = stable_cnt;
    end else begin
      next_cnt = stable_cnt + CNT_W'(1);
    end
    // Only the scan on which the count arrives at the threshold updates the debounced state.
    reach       = scan_end && (next_cnt == CNT_W'(DEBOUNCE_SCANS)) &&
                  (!same || (stable_cnt != CNT_W'(DEBOUNCE_SCANS)));
    press_event = reach && cand_pressed && (!key_down || (deb_code != cand_code));
  end

  // Synchronizer, row scanning and debounce state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta     <= 4'hF;
      col_sync     <= 4'hF;
      slot         <= '0;
      row          <= 2'd0;
      row_pins     <= 4'b1110;
      acc_pressed  <= 1'b0;
      acc_code     <= 4'd0;
      prev_pressed <= 1'b0;
      prev_code    <= 4'd0;
      stable_cnt   <= '0;
      key_down     <= 1'b0;
      deb_code     <= 4'd0;
    end else begin
      col_meta <= col_pins;
      col_sync <= col_meta;
      if (slot_end) begin
        slot        <= '0;
        row         <= row + 2'd1;
        row_pins    <= ~(4'b0001 << (row + 2'd1));
        acc_pressed <= cand_pressed;
        acc_code    <= cand_code;
        if (scan_end) begin
          prev_pressed <= cand_pressed;
          prev_code    <= cand_code;
          stable_cnt   <= next_cnt;
          if (reach) begin
            key_down <= cand_pressed;
            deb_code <= cand_code;
          end
        end
      end else begin
        slot <= slot + SLOT_W'(1);
      end
    end
  end

`ifdef KEYPAD_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n;
  logic [PTR_W:0]   count, count_n;
  logic             pop, push, drop;
  logic [3:0]       head_n;

  // Queue bookkeeping; a push into a full queue is allowed only alongside a pop.
  always_comb begin
    pop     = key_ack && (count != '0);
    push    = press_event && ((count != (PTR_W+1)'(FIFO_DEPTH)) || pop);
    drop    = press_event && !push;
    count_n = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    rd_n    = rd_ptr + PTR_W'(pop);
    // A lone entry written this cycle is not yet in mem, so forward it.
    head_n  = (push && (count_n == (PTR_W+1)'(1))) ? cand_code : mem[rd_n];
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand_code;
  end

  // Queue pointers and registered head/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_n;
      count     <= count_n;
      key_valid <= (count_n != '0);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (count_n != '0) key_code <= head_n;
      if (drop) begin
        overflow <= 1'b1;
      end else if (pop) begin
        overflow <= 1'b0;
      end
    end
  end
`else
  logic pop;

  always_comb begin
    pop = key_ack && key_valid;
  end

  // Single holding register; pop happens before load so ack+event keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      if (press_event && (!key_valid || pop)) begin
        key_valid <= 1'b1;
        key_code  <= cand_code;
      end else if (pop) begin
        key_valid <= 1'b0;
      end
      if (press_event && key_valid && !pop) begin
        overflow <= 1'b1;
      end else if (pop) begin
        overflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dev_keypad.sv
// Testbench for dev_keypad: keypad matrix model on the pins, a scan-level
// reference model of debounce and key queue, per-cycle output comparison,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dev_keypad;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FD = 4;
`ifdef KEYPAD_FIFO_EN
  localparam int CAP = FD;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_pins, col_pins, key_code;
  logic        key_valid, key_ack, key_down, overflow;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dev_keypad #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .row_pins(row_pins), .col_pins(col_pins),
    .key_valid(key_valid), .key_code(key_code), .key_ack(key_ack),
    .key_down(key_down), .overflow(overflow)
  );

  // Keypad matrix: a held key shorts its column to its row when that row is driven low.
  always_comb begin
    col_pins = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row_pins[r] == 1'b0) col_pins = col_pins & ~keys[r*4 +: 4];
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Key identity is its bit index row*4+col; -1 means "nothing pressed".
  typedef struct packed {
    int          n;
    logic [15:0] img;
    int          prev;
    int          run;
    int          deb;
  } scan_t;

  function automatic scan_t scan_step(input scan_t s_in, input logic [3:0] col, output int ev);
    scan_t s;
    int    row, slot, cand;
    bit    reach;
    s = s_in;
    ev = -1;
    reach = 0;
    slot = s.n % SD;
    row = (s.n / SD) % 4;
    if (slot == SD - 1) begin
      if (row == 0) s.img = '0;
      for (int c = 0; c < 4; c++) s.img[row*4 + c] = ~col[c];
      if (row == 3) begin
        cand = -1;
        for (int i = 15; i >= 0; i--) if (s.img[i]) cand = i;
        if (cand == s.prev) begin
          if (s.run < DB) begin
            s.run = s.run + 1;
            reach = (s.run == DB);
          end
        end else begin
          s.prev = cand;
          s.run = 1;
          reach = (DB == 1);
        end
        if (reach) begin
          if (cand >= 0 && cand != s.deb) ev = cand;
          s.deb = cand;
        end
      end
    end
    s.n = s.n + 1;
    return s;
  endfunction

  scan_t      ms;
  logic [3:0] h1, h2;
  int         q[$];
  bit         m_ovf;
  int         m_ev_next = -1;
  int         m_events = 0;
  bit         m_ready = 0;

  always @(posedge clk) begin
    int         ev, dummy_ev;
    logic [3:0] samp;
    scan_t      tmp;
    if (rst_n === 1'b0) begin
      ms.n = 0; ms.img = '0; ms.prev = -1; ms.run = 0; ms.deb = -1;
      h1 = 4'hF; h2 = 4'hF;
      q.delete();
      m_ovf = 0;
      m_ev_next = -1;
      m_ready = 1;
    end else if (m_ready) begin
      // Columns reach the scanner two clocks after they appear on the pins.
      samp = h2;
      h2 = h1;
      h1 = col_pins;
      ms = scan_step(ms, samp, ev);
      if (key_ack && q.size() > 0) begin
        void'(q.pop_front());
        m_ovf = 0;
      end
      if (ev >= 0) begin
        m_events++;
        if (q.size() < CAP) q.push_back(ev);
        else m_ovf = 1;
      end
      tmp = scan_step(ms, h2, dummy_ev);
      m_ev_next = dummy_ev;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] er;
    if (m_ready) begin
      er = ~(4'b0001 << ((ms.n / SD) % 4));
      check("row_pins", 16'(row_pins), 16'(er));
      check("key_valid", 16'(key_valid), 16'(q.size() > 0));
      check("key_down", 16'(key_down), 16'(ms.deb >= 0));
      check("overflow", 16'(overflow), 16'(m_ovf));
      if (q.size() > 0) check("key_code", 16'(key_code), 16'(q[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic wait_event(input string name, input int budget, output int waited);
    int start;
    start = m_events;
    waited = 0;
    while (m_events == start && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check(name, 16'(m_events != start), 16'd1);
  endtask

  initial begin
    logic [3:0] rows_exp [16];
    int         w, mode, len, k1, n;
    rows_exp = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD, 4'hB,
                 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hE};
    keys = 16'h0;
    key_ack = 1'b0;
    rst_n = 1'b0;

    do_reset(3);
    check("rst_row_pins", 16'(row_pins), 16'hE);
    check("rst_key_valid", 16'(key_valid), 16'd0);
    check("rst_key_code", 16'(key_code), 16'd0);
    check("rst_key_down", 16'(key_down), 16'd0);
    check("rst_overflow", 16'(overflow), 16'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("row_sequence", 16'(row_pins), 16'(rows_exp[i]));
    end

    // Single press of row 2 col 1, held.
    keys = 16'h1 << 9;
    wait_event("press9_event", 60, w);
    check("press9_latency_ok", 16'(w <= 51), 16'd1);
    check("press9_valid", 16'(key_valid), 16'd1);
    check("press9_code", 16'(key_code), 16'h9);
    check("press9_down", 16'(key_down), 16'd1);
    cycles(160);
    check("hold_no_repeat", 16'(overflow), 16'd0);
    check("hold_code", 16'(key_code), 16'h9);
    ack();
    check("ack_clears_valid", 16'(key_valid), 16'd0);
    keys = 16'h0;
    cycles(48);
    check("release_down", 16'(key_down), 16'd0);
    check("release_no_event", 16'(key_valid), 16'd0);

    // Bounce on key 0, then hold it.
    for (int i = 0; i < 8; i++) begin
      keys[0] = ~keys[0];
      cycles(5);
    end
    keys = 16'h0001;
    cycles(64);
    check("bounce_valid", 16'(key_valid), 16'd1);
    check("bounce_code", 16'(key_code), 16'h0);
    check("bounce_down", 16'(key_down), 16'd1);
    n = 0;
    while (key_valid && n < 8) begin
      ack();
      n++;
    end
    keys = 16'h0;
    cycles(48);

    // Two keys together resolve to the lower code.
    keys = (16'h1 << 7) | (16'h1 << 14);
    wait_event("multi_event", 60, w);
    check("multi_code", 16'(key_code), 16'h7);
    ack();
    keys = 16'h0;
    cycles(48);

`ifndef KEYPAD_FIFO_EN
    // Second press while the first is still pending is dropped.
    keys = 16'h1 << 3;
    wait_event("ovf_first", 60, w);
    keys = 16'h0;
    cycles(48);
    keys = 16'h1 << 5;
    wait_event("ovf_second", 60, w);
    check("ovf_valid", 16'(key_valid), 16'd1);
    check("ovf_code_kept", 16'(key_code), 16'h3);
    check("ovf_set", 16'(overflow), 16'd1);
    ack();
    check("ovf_ack_valid", 16'(key_valid), 16'd0);
    check("ovf_ack_clear", 16'(overflow), 16'd0);
    keys = 16'h0;
    cycles(48);

    // Ack on the exact cycle of the second event: pop then load.
    keys = 16'h1 << 3;
    wait_event("same_cycle_first", 60, w);
    keys = 16'h0;
    cycles(48);
    keys = 16'h1 << 5;
    n = 0;
    while (m_ev_next < 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("same_cycle_found", 16'(m_ev_next >= 0), 16'd1);
    ack();
    check("same_cycle_code", 16'(key_code), 16'h5);
    check("same_cycle_valid", 16'(key_valid), 16'd1);
    check("same_cycle_ovf", 16'(overflow), 16'd0);
    ack();
    keys = 16'h0;
    cycles(48);
`else
    // Five presses into a four-deep queue.
    for (int k = 1; k <= 5; k++) begin
      keys = 16'h1 << k;
      wait_event("fifo_press", 60, w);
      keys = 16'h0;
      cycles(48);
    end
    check("fifo_ovf", 16'(overflow), 16'd1);
    for (int k = 1; k <= 4; k++) begin
      check("fifo_valid", 16'(key_valid), 16'd1);
      check("fifo_code", 16'(key_code), 16'(k));
      ack();
    end
    check("fifo_empty", 16'(key_valid), 16'd0);
    check("fifo_ovf_clear", 16'(overflow), 16'd0);
`endif

    // Reset in the middle of a scan.
    keys = 16'h1 << 10;
    cycles(21);
    do_reset(2);
    check("midscan_row_pins", 16'(row_pins), 16'hE);
    check("midscan_valid", 16'(key_valid), 16'd0);
    check("midscan_down", 16'(key_down), 16'd0);

    // Randomized presses, chords, bounce and acks.
    repeat (40) begin
      mode = $urandom_range(0, 3);
      len = $urandom_range(10, 80);
      k1 = $urandom_range(0, 15);
      case (mode)
        0: keys = 16'h0;
        1: keys = 16'h1 << k1;
        2: keys = (16'h1 << k1) | (16'h1 << $urandom_range(0, 15));
        default: keys = 16'h1 << k1;
      endcase
      for (int t = 0; t < len; t++) begin
        if (mode == 3 && $urandom_range(0, 3) == 0) keys[k1] = ~keys[k1];
        key_ack = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      key_ack = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
